multiline_block_scheduler: RTL
==============================

MULTILINE_BLOCK_SCHEDULER -- requirements
Module: multiline_block_scheduler

Interface
REQ-001 SHALL have parameter BUF_AMOUNT, default 8: number of line-buffer inputs, which equals the block height.
REQ-002 SHALL have parameter BLOCK_W, default 8: block width in pixels.
REQ-003 SHALL have parameter PX_WIDTH, default 8: pixel width in bits; TDATA_WIDTH is PX_WIDTH rounded up to a multiple of 8.
REQ-004 SHALL have parameter FRAME_RES_X, default 1280: pixels per line, a multiple of BLOCK_W.
REQ-005 SHALL have parameter FRAME_RES_Y, default 720: lines per frame, a multiple of BUF_AMOUNT.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port video_i, axi4_stream_if.slave array [BUF_AMOUNT-1:0], TDATA_WIDTH bits: line-buffer outputs; tdata, tvalid, tready, tlast and tuser are used.
REQ-009 SHALL have port block_o, axi4_stream_if.master, TDATA_WIDTH bits: block stream carrying tdata, tvalid, tready, tlast and tuser; tstrb/tkeep all-ones, tid/tdest 0.
REQ-010 SHALL have port frame_done_o, output, 1 bit: one-cycle pulse when the last pixel of a frame is accepted from the inputs.
REQ-011 SHALL have port err_o, output, 1 bit: sticky line-length error.

Function
REQ-012 SHALL keep counters px_cnt (0..BLOCK_W-1), row_cnt (0..BUF_AMOUNT-1), col_cnt (0..FRAME_RES_X/BLOCK_W-1) and brow_cnt (0..FRAME_RES_Y/BUF_AMOUNT-1).
REQ-013 SHALL implement FSM states WAIT_SOF and RUN.
REQ-014 In WAIT_SOF, SHALL drive video_i[0].tready = !video_i[0].tuser, discarding row-0 words until one arrives with tuser=1; that word is not consumed.
REQ-015 In WAIT_SOF, SHALL hold all other video_i[k].tready at 0.
REQ-016 SHALL move WAIT_SOF->RUN when video_i[0].tvalid && video_i[0].tuser, and load all counters with 0.
REQ-017 In RUN, SHALL assert only video_i[row_cnt].tready, with value adv = !block_o.tvalid || block_o.tready; all other inputs see tready=0.
REQ-018 An input transfer (video_i[row_cnt].tvalid && adv in RUN) SHALL load the output register with that tdata and set block_o.tvalid=1, giving a latency of 1 cycle.
REQ-019 If block_o.tready=1 and no input transfer occurs in the same cycle, SHALL clear block_o.tvalid.
REQ-020 While block_o.tvalid=1 && block_o.tready=0, SHALL hold block_o stable.
REQ-021 On each transfer, SHALL increment px_cnt; at BLOCK_W-1 it wraps and row_cnt increments.
REQ-022 When row_cnt wraps, col_cnt SHALL increment.
REQ-023 When col_cnt wraps, brow_cnt SHALL increment.
REQ-024 Pixel order within a block SHALL be row-major: BLOCK_W pixels from input 0, then from input 1, and so on to input BUF_AMOUNT-1.
REQ-025 SHALL set block_o.tlast=1 on the last pixel of each block (px_cnt=BLOCK_W-1, row_cnt=BUF_AMOUNT-1).
REQ-026 SHALL set block_o.tuser=1 only on the first pixel of a frame (all counters 0).
REQ-027 Input tlast is expected exactly when px_cnt=BLOCK_W-1 and col_cnt is at its maximum; any mismatch on a transfer SHALL set err_o=1 until reset.
REQ-028 On a tlast mismatch, the counters SHALL continue without resynchronisation.
REQ-029 On the transfer where all four counters are at maximum, SHALL pulse frame_done_o for one cycle and enter WAIT_SOF.
REQ-030 In RUN, SHALL ignore input tuser; a tuser=1 mid-frame is passed through as data and does not restart the frame.
REQ-031 Output-side backpressure SHALL propagate only through adv; data SHALL be neither lost nor duplicated.

Reset
REQ-032 On rst_i=1 at a clock edge, SHALL set state=WAIT_SOF, all counters=0, block_o.tvalid=0, block_o.tlast=0, block_o.tuser=0, block_o.tdata=0, frame_done_o=0 and err_o=0.
REQ-033 While rst_i=1, all video_i[k].tready SHALL be 0.
REQ-034 Reset asserted mid-block SHALL abandon the partial block with no further output and restart at WAIT_SOF.

Verification (FRAME_RES_X=16, FRAME_RES_Y=16, BLOCK_W=8, BUF_AMOUNT=8)
REQ-035 Full frame: input k carries value 16*line+x on line 8*b+k, tready=1 throughout -> 4 blocks of 64 words each; block 0 is 0..7, 16..23, ..., 112..119; tlast on words 63/127/191/255; tuser only on word 0; one frame_done_o pulse; err_o=0.
REQ-036 Preamble: 5 words with tuser=0 on input 0 before the SOF word -> those 5 are dropped; first output is the SOF word with tuser=1.
REQ-037 Backpressure: block_o.tready toggled 1-0-1 each cycle -> output identical to REQ-035; block_o stable during stalls; no extra input handshakes.
REQ-038 Starvation: input 3 tvalid=0 for 10 cycles at row_cnt=3 -> no output during the gap, no tready on other inputs, and the sequence then continues correctly.
REQ-039 Short line: input 0 asserts tlast at x=7 on a 16-pixel line -> err_o=1 from the next cycle and held until rst_i.
REQ-040 Mid-block reset: rst_i pulsed after 20 outputs -> block_o.tvalid=0 the next cycle; the next frame after a new SOF starts at tuser=1 with correct data.

Source files
------------

// File: rtl/multiline_block_scheduler_if.sv
// AXI4-Stream bundle shared by the line-buffer inputs and the block output.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 8
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic                     tvalid;
  logic                     tready;
  logic                     tlast;
  logic                     tuser;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tid;
  logic                     tdest;

  modport master (
    output tdata, tvalid, tlast, tuser, tstrb, tkeep, tid, tdest,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tuser, tstrb, tkeep, tid, tdest,
    output tready
  );
endinterface

// File: rtl/multiline_block_scheduler.sv
// Reorders BUF_AMOUNT parallel line streams into BLOCK_W x BUF_AMOUNT pixel blocks,
// emitted row-major through a single-entry output register.
module multiline_block_scheduler #(
  parameter int BUF_AMOUNT  = 8,
  parameter int BLOCK_W     = 8,
  parameter int PX_WIDTH    = 8,
  parameter int FRAME_RES_X = 1280,
  parameter int FRAME_RES_Y = 720
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  video_i [BUF_AMOUNT-1:0],
  axi4_stream_if.master block_o,
  output logic          frame_done_o,
  output logic          err_o
);

  localparam int TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8;
  localparam int COLS        = FRAME_RES_X / BLOCK_W;
  localparam int BROWS       = FRAME_RES_Y / BUF_AMOUNT;
  localparam int PX_W        = (BLOCK_W    > 1) ? $clog2(BLOCK_W)    : 1;
  localparam int ROW_W       = (BUF_AMOUNT > 1) ? $clog2(BUF_AMOUNT) : 1;
  localparam int COL_W       = (COLS       > 1) ? $clog2(COLS)       : 1;
  localparam int BROW_W      = (BROWS      > 1) ? $clog2(BROWS)      : 1;

  typedef enum logic {S_WAIT_SOF, S_RUN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PX_W-1:0]   r_px;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [BROW_W-1:0] r_brow;

  logic [TDATA_WIDTH-1:0] r_tdata_p1;
  logic                   r_tvalid_p1;
  logic                   r_tlast_p1;
  logic                   r_tuser_p1;
  logic                   r_frame_done;
  logic                   r_err;

  logic [TDATA_WIDTH-1:0] w_tdata  [BUF_AMOUNT];
  logic [BUF_AMOUNT-1:0]  w_tvalid;
  logic [BUF_AMOUNT-1:0]  w_tlast;
  logic [BUF_AMOUNT-1:0]  w_tuser;
  logic [BUF_AMOUNT-1:0]  w_tready;

  logic w_adv;
  logic w_xfer;
  logic w_sof;
  logic w_px_last;
  logic w_row_last;
  logic w_col_last;
  logic w_brow_last;
  logic w_frame_last;
  logic w_first;

  // Interface arrays only allow constant indices, so flatten them here.
  for (genvar g = 0; g < BUF_AMOUNT; g++) begin : g_in
    assign w_tdata[g]         = video_i[g].tdata;
    assign w_tvalid[g]        = video_i[g].tvalid;
    assign w_tlast[g]         = video_i[g].tlast;
    assign w_tuser[g]         = video_i[g].tuser;
    assign video_i[g].tready  = w_tready[g];
  end

  assign w_px_last    = (r_px   == PX_W'(BLOCK_W - 1));
  assign w_row_last   = (r_row  == ROW_W'(BUF_AMOUNT - 1));
  assign w_col_last   = (r_col  == COL_W'(COLS - 1));
  assign w_brow_last  = (r_brow == BROW_W'(BROWS - 1));
  assign w_frame_last = w_px_last && w_row_last && w_col_last && w_brow_last;
  assign w_first      = (r_px == '0) && (r_row == '0) && (r_col == '0) && (r_brow == '0);

  assign w_adv  = !r_tvalid_p1 || block_o.tready;
  assign w_xfer = !rst_i && (r_state == S_RUN) && w_tvalid[r_row] && w_adv;
  assign w_sof  = !rst_i && (r_state == S_WAIT_SOF) && w_tvalid[0] && w_tuser[0];

  always_comb begin
    w_state_nxt = r_state;
    w_tready    = '0;
    if (!rst_i) begin
      case (r_state)
        S_WAIT_SOF: begin
          // Drain pre-frame words on row 0 but leave the SOF word in place.
          w_tready[0] = !w_tuser[0];
          if (w_sof) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          w_tready[r_row] = w_adv;
          if (w_xfer && w_frame_last) w_state_nxt = S_WAIT_SOF;
        end
        default: w_state_nxt = S_WAIT_SOF;
      endcase
    end
  end

  // Stage p0 -> p1: input mux into the output register, counters advance per transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_WAIT_SOF;
      r_px         <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_brow       <= '0;
      r_tdata_p1   <= '0;
      r_tvalid_p1  <= 1'b0;
      r_tlast_p1   <= 1'b0;
      r_tuser_p1   <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= 1'b0;
      if (w_sof) begin
        r_px   <= '0;
        r_row  <= '0;
        r_col  <= '0;
        r_brow <= '0;
      end
      if (w_xfer) begin
        r_tdata_p1   <= w_tdata[r_row];
        r_tvalid_p1  <= 1'b1;
        r_tlast_p1   <= w_px_last && w_row_last;
        r_tuser_p1   <= w_first;
        r_frame_done <= w_frame_last;
        // A line-length mismatch is only flagged; counting carries on unchanged.
        if (w_tlast[r_row] != (w_px_last && w_col_last)) r_err <= 1'b1;
        if (w_px_last) begin
          r_px <= '0;
          if (w_row_last) begin
            r_row <= '0;
            if (w_col_last) begin
              r_col  <= '0;
              r_brow <= w_brow_last ? '0 : r_brow + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end else begin
            r_row <= r_row + 1'b1;
          end
        end else begin
          r_px <= r_px + 1'b1;
        end
      end else if (block_o.tready) begin
        r_tvalid_p1 <= 1'b0;
      end
    end
  end

  assign block_o.tdata  = r_tdata_p1;
  assign block_o.tvalid = r_tvalid_p1;
  assign block_o.tlast  = r_tlast_p1;
  assign block_o.tuser  = r_tuser_p1;
  assign block_o.tstrb  = '1;
  assign block_o.tkeep  = '1;
  assign block_o.tid    = 1'b0;
  assign block_o.tdest  = 1'b0;
  assign frame_done_o   = r_frame_done;
  assign err_o          = r_err;

endmodule
